// File: rtl/trit_group_ctrl.sv
// -----------------------------------------------------------------------------
// trit_group_ctrl
//
// Purpose:
//   Collects a frame of N_TRITS balanced-free ternary digits (trits), groups
//   them five at a time, and drives an external trit-to-binary converter
//   through a fixed load / accumulate / capture sequence.
//
//   Each group of five trits becomes one byte. The byte is presented on a
//   valid/ready handshake. A frame that does not fill its last group is
//   padded with zero trits.
//
// Ports:
//   clk          in   rising-edge clock (the only clock)
//   rst          in   asynchronous active-high reset
//   start        in   one-cycle frame-start pulse (ignored while busy)
//   trit_in      in   trit code: 00=0, 01=1, 11=2, 10=illegal
//   trit_valid   in   upstream trit valid
//   trit_ready   out  block accepts trit_in (COLLECT only)
//   conv_a       out  5-trit group, trit i in bits [2i+1:2i]
//   conv_rst     out  converter load strobe (LOAD only)
//   conv_count   out  converter accumulate step 0..3 (ACC only)
//   conv_out     in   converter result byte, final during CAPT
//   byte_out     out  packed byte
//   byte_valid   out  byte_out valid (OUT only)
//   byte_ready   in   downstream accepts byte_out
//   byte_last    out  byte_out is the frame's final byte
//   busy         out  frame in progress (any state but IDLE)
//   err          out  sticky illegal-trit flag, cleared by start or rst
// -----------------------------------------------------------------------------
module trit_group_ctrl #(
  parameter int N_TRITS = 700
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [1:0] trit_in,
  input  logic       trit_valid,
  output logic       trit_ready,
  output logic [9:0] conv_a,
  output logic       conv_rst,
  output logic [1:0] conv_count,
  input  logic [7:0] conv_out,
  output logic [7:0] byte_out,
  output logic       byte_valid,
  input  logic       byte_ready,
  output logic       byte_last,
  output logic       busy,
  output logic       err
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    COLLECT = 3'd1,
    LOAD    = 3'd2,
    ACC     = 3'd3,
    CAPT    = 3'd4,
    OUT     = 3'd5
  } state_t;

  localparam logic [10:0] N_LAST = 11'(N_TRITS);

  state_t     state_q, state_d;
  logic [9:0] trit_cnt_q, trit_cnt_d;
  logic [2:0] slot_q, slot_d;
  logic [9:0] group_q, group_d;
  logic [1:0] acc_q, acc_d;
  logic [7:0] byte_q, byte_d;
  logic       last_q, last_d;
  logic       err_q, err_d;

  // Output flops: every output is decoded from the next state so it
  // changes cleanly on the clock edge together with the state register.
  logic       trit_ready_q, trit_ready_d;
  logic       conv_rst_q, conv_rst_d;
  logic [1:0] conv_count_q, conv_count_d;
  logic       byte_valid_q, byte_valid_d;
  logic       byte_last_q, byte_last_d;
  logic       busy_q, busy_d;

  logic [1:0]  code_s;
  logic        illegal_s;
  logic [10:0] cnt_inc_s;

  // Illegal code 10 is accepted but stored as a zero trit.
  assign illegal_s = (trit_in == 2'b10);
  assign code_s    = illegal_s ? 2'b00 : trit_in;
  assign cnt_inc_s = {1'b0, trit_cnt_q} + 11'd1;

  // Next-state, datapath and output decode.
  always_comb begin
    state_d    = state_q;
    trit_cnt_d = trit_cnt_q;
    slot_d     = slot_q;
    group_d    = group_q;
    acc_d      = acc_q;
    byte_d     = byte_q;
    last_d     = last_q;
    err_d      = err_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = COLLECT;
          trit_cnt_d = 10'd0;
          slot_d     = 3'd0;
          group_d    = 10'd0;
          last_d     = 1'b0;
          err_d      = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end

      COLLECT: begin
        if (trit_valid && trit_ready_q) begin
          for (int i = 0; i < 5; i++) begin
            if (slot_q == 3'(i)) begin
              group_d[2*i +: 2] = code_s;
            end else begin
              group_d[2*i +: 2] = group_q[2*i +: 2];
            end
          end
          if (illegal_s) begin
            err_d = 1'b1;
          end else begin
            err_d = err_q;
          end
          trit_cnt_d = cnt_inc_s[9:0];
          // A group closes on its fifth trit or on the frame's final trit;
          // slots not yet written remain zero from the group clear.
          if ((slot_q == 3'd4) || (cnt_inc_s == N_LAST)) begin
            state_d = LOAD;
            slot_d  = 3'd0;
            last_d  = (cnt_inc_s == N_LAST);
          end else begin
            slot_d = slot_q + 3'd1;
          end
        end else begin
          state_d = COLLECT;
        end
      end

      LOAD: begin
        state_d = ACC;
        acc_d   = 2'd0;
      end

      ACC: begin
        acc_d = acc_q + 2'd1;
        if (acc_q == 2'd3) begin
          state_d = CAPT;
        end else begin
          state_d = ACC;
        end
      end

      CAPT: begin
        byte_d  = conv_out;
        state_d = OUT;
      end

      OUT: begin
        if (byte_ready) begin
          group_d = 10'd0;
          if (last_q) begin
            state_d = IDLE;
          end else begin
            state_d = COLLECT;
          end
        end else begin
          state_d = OUT;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    trit_ready_d = (state_d == COLLECT);
    conv_rst_d   = (state_d == LOAD);
    conv_count_d = (state_d == ACC) ? acc_d : 2'd0;
    byte_valid_d = (state_d == OUT);
    byte_last_d  = (state_d == OUT) && last_d;
    busy_d       = (state_d != IDLE);
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      trit_cnt_q   <= 10'd0;
      slot_q       <= 3'd0;
      group_q      <= 10'd0;
      acc_q        <= 2'd0;
      byte_q       <= 8'd0;
      last_q       <= 1'b0;
      err_q        <= 1'b0;
      trit_ready_q <= 1'b0;
      conv_rst_q   <= 1'b0;
      conv_count_q <= 2'd0;
      byte_valid_q <= 1'b0;
      byte_last_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      trit_cnt_q   <= trit_cnt_d;
      slot_q       <= slot_d;
      group_q      <= group_d;
      acc_q        <= acc_d;
      byte_q       <= byte_d;
      last_q       <= last_d;
      err_q        <= err_d;
      trit_ready_q <= trit_ready_d;
      conv_rst_q   <= conv_rst_d;
      conv_count_q <= conv_count_d;
      byte_valid_q <= byte_valid_d;
      byte_last_q  <= byte_last_d;
      busy_q       <= busy_d;
    end
  end

  assign trit_ready = trit_ready_q;
  assign conv_a     = group_q;
  assign conv_rst   = conv_rst_q;
  assign conv_count = conv_count_q;
  assign byte_out   = byte_q;
  assign byte_valid = byte_valid_q;
  assign byte_last  = byte_last_q;
  assign busy       = busy_q;
  assign err        = err_q;

endmodule
